// File: rtl/board_loader.sv
// ============================================================================
// Module  : board_loader
// Purpose : Streams a latched 36-tile board (24 edge + 12 center slots) into
//           board memory with a ready/valid handshake. Optional illegal-code
//           abort is enabled by defining TILE_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module board_loader #(
    parameter int EDGE_N   = 24,
    parameter int CENTER_N = 12,
    parameter int TILE_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [EDGE_N*TILE_W-1:0]   edge_order,
    input  logic [CENTER_N*TILE_W-1:0] center_order,
    output logic                       wr_en,
    output logic [5:0]                 wr_addr,
    output logic [TILE_W-1:0]          wr_data,
    input  logic                       wr_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int         c_SLOTS     = EDGE_N + CENTER_N;
    localparam logic [5:0] c_LAST_EDGE = 6'(EDGE_N - 1);
    localparam logic [5:0] c_LAST_SLOT = 6'(c_SLOTS - 1);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_LOAD_EDGE   = 2'd1;
    localparam logic [1:0] c_LOAD_CENTER = 2'd2;
    localparam logic [1:0] c_FINISH      = 2'd3;

    logic [1:0]                 r_state;
    logic [5:0]                 r_ptr;
    logic [EDGE_N*TILE_W-1:0]   r_edge;
    logic [CENTER_N*TILE_W-1:0] r_center;

    logic                       w_loading;
    logic                       w_xfer;
    logic                       w_bad;
    logic [TILE_W-1:0]          w_slot [c_SLOTS];

    // Flat view of the latched board so the write pointer indexes it directly.
    generate
        for (genvar i = 0; i < EDGE_N; i++) begin : g_edge_slot
            assign w_slot[i] = r_edge[i*TILE_W +: TILE_W];
        end
        for (genvar j = 0; j < CENTER_N; j++) begin : g_center_slot
            assign w_slot[EDGE_N + j] = r_center[j*TILE_W +: TILE_W];
        end
    endgenerate

    assign w_loading = (r_state == c_LOAD_EDGE) || (r_state == c_LOAD_CENTER);
    assign w_xfer    = w_loading && wr_ready;

    // Outputs decode from state only, so the async reset clears them at once.
    assign wr_en   = w_loading;
    assign busy    = w_loading;
    assign done    = (r_state == c_FINISH);
    assign wr_addr = w_loading ? r_ptr : 6'd0;
    assign wr_data = w_loading ? w_slot[r_ptr] : '0;

`ifdef TILE_CHECK_EN
    localparam logic [TILE_W-1:0] c_MAX_CODE = TILE_W'(11);

    logic r_err;

    assign w_bad = w_xfer && (wr_data > c_MAX_CODE);
    assign err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == c_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_ptr    <= 6'd0;
            r_edge   <= '0;
            r_center <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_edge   <= edge_order;
                        r_center <= center_order;
                        r_ptr    <= 6'd0;
                        r_state  <= c_LOAD_EDGE;
                    end
                end
                c_LOAD_EDGE: begin
                    if (w_xfer) begin
                        r_ptr <= r_ptr + 6'd1;
                        if (w_bad) begin
                            r_state <= c_FINISH;
                        end else if (r_ptr == c_LAST_EDGE) begin
                            r_state <= c_LOAD_CENTER;
                        end
                    end
                end
                c_LOAD_CENTER: begin
                    if (w_xfer) begin
                        r_ptr <= r_ptr + 6'd1;
                        if (w_bad || (r_ptr == c_LAST_SLOT)) begin
                            r_state <= c_FINISH;
                        end
                    end
                end
                c_FINISH: begin
                    r_ptr   <= 6'd0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_ptr   <= 6'd0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_board_loader.sv
// ============================================================================
// Module  : tb_board_loader
// Purpose : Directed self-checking bench for board_loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_board_loader;

`ifdef TILE_CHECK_EN
    localparam bit c_CHK = 1'b1;
`else
    localparam bit c_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [95:0] edge_order = '0;
    logic [47:0] center_order = '0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        wr_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    board_loader #(.EDGE_N(24), .CENTER_N(12), .TILE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .edge_order   (edge_order),
        .center_order (center_order),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_code(input int k, input bit bad7);
        if (k < 24) return (bad7 && k == 7) ? 4'd13 : 4'(k % 12);
        return 4'(k - 24);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   32'(wr_en),   32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
    endtask

    // mode 0: ready held 1; mode 1: ready 1,0,1,0...; mode 2: ready 1, edge_order
    // overwritten at cycle 5. abort_at>0 asserts rst at that cycle.
    task automatic run_load(input int mode, input bit bad7, input int abort_at, input bit hold_start);
        int  exp_ptr;
        int  total;
        int  exp_done_cyc;
        bit  done_seen;
        bit  finished;
        for (int i = 0; i < 24; i++) edge_order[4*i +: 4] = exp_code(i, bad7);
        for (int j = 0; j < 12; j++) center_order[4*j +: 4] = 4'(j);
        total        = (bad7 && c_CHK) ? 8 : 36;
        exp_done_cyc = (mode == 1) ? 2 * total : total + 1;
        exp_ptr      = 0;
        done_seen    = 1'b0;
        finished     = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        wr_ready = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            wr_ready = (mode == 1) ? c[0] : 1'b1;
            if (mode == 2 && c == 5) edge_order = '1;
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (wr_en || done) begin
                        check("post_abort_quiet", {30'd0, wr_en, done}, 32'd0);
                        break;
                    end
                end
                check("post_abort_idle", {30'd0, wr_en, done}, 32'd0);
                finished = 1'b1;
                break;
            end
            if (exp_ptr < total) begin
                check("ld_wr_en",   32'(wr_en),   32'd1);
                check("ld_busy",    32'(busy),    32'd1);
                check("ld_done",    32'(done),    32'd0);
                check("ld_wr_addr", 32'(wr_addr), 32'(exp_ptr));
                check("ld_wr_data", 32'(wr_data), 32'(exp_code(exp_ptr, bad7)));
                if (wr_ready) exp_ptr++;
            end else if (!done_seen) begin
                check("fin_done",  32'(done),  32'd1);
                check("fin_wr_en", 32'(wr_en), 32'd0);
                check("fin_busy",  32'(busy),  32'd0);
                check("fin_cycle", 32'(c),     32'(exp_done_cyc));
                check("fin_err",   32'(err),   32'(bad7 && c_CHK));
                done_seen = 1'b1;
            end else begin
                check("idle_done",    32'(done),    32'd0);
                check("idle_wr_en",   32'(wr_en),   32'd0);
                check("idle_busy",    32'(busy),    32'd0);
                check("idle_wr_addr", 32'(wr_addr), 32'd0);
                check("idle_wr_data", 32'(wr_data), 32'd0);
                finished = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("load_timeout", 32'(finished), 32'd1);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        run_load(0, 1'b0, 0, 1'b0);
        run_load(1, 1'b0, 0, 1'b0);
        run_load(2, 1'b0, 0, 1'b0);
        run_load(0, 1'b0, 10, 1'b0);
        run_load(0, 1'b0, 0, 1'b0);
        run_load(0, 1'b1, 0, 1'b0);

        // start held through FINISH: ignored there, accepted again once in IDLE
        run_load(0, 1'b0, 0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("restart_wr_en",   32'(wr_en),   32'd1);
        check("restart_wr_addr", 32'(wr_addr), 32'd0);
        check("restart_busy",    32'(busy),    32'd1);
        rst = 1'b1;
        #1 check_all_zero("cleanup");
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
